// File: rtl/jogo_pkg.sv
// Shared game definitions: guess FSM states and default game dimensions.
`default_nettype none

package jogo_pkg;

    localparam int W_PADRAO              = 6;
    localparam int MAX_TENTATIVAS_PADRAO = 10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OFFER    = 2'd1,
        S_WAIT_REL = 2'd2,
        S_LOCKED   = 2'd3
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/debounce_botao.sv
// Two-flop synchroniser, debouncer and press-edge detector for an active-low push-button.
`default_nettype none

module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_botao_n,
    output logic o_pressionado,
    output logic o_press_pulse
);

    localparam int              CNTW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNTW-1:0] C_ULTIMO = CNTW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_nivel_n;
    logic [CNTW-1:0] r_cnt;
    logic            r_pulse;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample,
    // so the counter only ever needs to reach DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_nivel_n <= 1'b1;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1 <= i_botao_n;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_nivel_n) begin
                r_cnt <= '0;
            end else if (r_cnt == C_ULTIMO) begin
                r_cnt     <= '0;
                r_nivel_n <= r_sync2;
                r_pulse   <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pressionado = ~r_nivel_n;
    assign o_press_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/captura_tentativa.sv
// Captures the switch guess on each debounced ENTER press and offers it over valid/ready,
// counting accepted guesses and locking out once the per-game limit is reached.
`default_nettype none

module captura_tentativa
    import jogo_pkg::*;
#(
    parameter int W               = W_PADRAO,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_TENTATIVAS  = MAX_TENTATIVAS_PADRAO,
    localparam int CW             = $clog2(MAX_TENTATIVAS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_enter_n,
    input  logic [W-1:0]  sw_tentativa,
    input  logic          novo_jogo,
    output logic [W-1:0]  tentativa,
    output logic          tentativa_valid,
    input  logic          tentativa_ready,
    output logic [CW-1:0] num_tentativas,
    output logic          esgotou
);

    localparam logic [CW-1:0] C_MAX = CW'(MAX_TENTATIVAS);

    logic w_pressionado;
    logic w_press_pulse;

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_botao_n     (key_enter_n),
        .o_pressionado (w_pressionado),
        .o_press_pulse (w_press_pulse)
    );

    estado_t         r_estado;
    logic [W-1:0]    r_tentativa;
    logic            r_valid;
    logic [CW-1:0]   r_num;
    logic            r_esgotou;

    estado_t         w_estado_prox;
    logic [W-1:0]    w_tentativa_prox;
    logic            w_valid_prox;
    logic [CW-1:0]   w_num_prox;
    logic            w_esgotou_prox;
    logic [CW-1:0]   w_num_inc;

    assign w_num_inc = r_num + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= S_IDLE;
            r_tentativa <= '0;
            r_valid     <= 1'b0;
            r_num       <= '0;
            r_esgotou   <= 1'b0;
        end else begin
            r_estado    <= w_estado_prox;
            r_tentativa <= w_tentativa_prox;
            r_valid     <= w_valid_prox;
            r_num       <= w_num_prox;
            r_esgotou   <= w_esgotou_prox;
        end
    end

    always_comb begin
        w_estado_prox    = r_estado;
        w_tentativa_prox = r_tentativa;
        w_valid_prox     = r_valid;
        w_num_prox       = r_num;
        w_esgotou_prox   = r_esgotou;

        // A new game overrides everything, including a transfer in this same cycle.
        if (novo_jogo) begin
            w_valid_prox   = 1'b0;
            w_num_prox     = '0;
            w_esgotou_prox = 1'b0;
            w_estado_prox  = w_pressionado ? S_WAIT_REL : S_IDLE;
        end else begin
            case (r_estado)
                S_IDLE: begin
                    if (w_press_pulse) begin
                        w_tentativa_prox = sw_tentativa;
                        w_valid_prox     = 1'b1;
                        w_estado_prox    = S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (r_valid && tentativa_ready) begin
                        w_valid_prox = 1'b0;
                        w_num_prox   = w_num_inc;
                        if (w_num_inc == C_MAX) begin
                            w_esgotou_prox = 1'b1;
                            w_estado_prox  = S_LOCKED;
                        end else if (w_pressionado) begin
                            w_estado_prox = S_WAIT_REL;
                        end else begin
                            w_estado_prox = S_IDLE;
                        end
                    end
                end
                S_WAIT_REL: begin
                    if (!w_pressionado) begin
                        w_estado_prox = S_IDLE;
                    end
                end
                S_LOCKED: begin
                    w_valid_prox = 1'b0;
                end
                default: begin
                    w_estado_prox = S_IDLE;
                    w_valid_prox  = 1'b0;
                end
            endcase
        end
    end

    assign tentativa       = r_tentativa;
    assign tentativa_valid = r_valid;
    assign num_tentativas  = r_num;
    assign esgotou         = r_esgotou;

endmodule

`default_nettype wire

// File: tb/tb_captura_tentativa.sv
// Directed self-checking bench for captura_tentativa with DEBOUNCE_CYCLES=4, MAX_TENTATIVAS=3.
`default_nettype none

module tb_captura_tentativa;

    localparam int W   = 6;
    localparam int DBC = 4;
    localparam int MAX = 3;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk;
    logic          rst_n;
    logic          key_enter_n;
    logic [W-1:0]  sw_tentativa;
    logic          novo_jogo;
    logic [W-1:0]  tentativa;
    logic          tentativa_valid;
    logic          tentativa_ready;
    logic [CW-1:0] num_tentativas;
    logic          esgotou;

    int n_checks = 0;
    int n_errors = 0;

    captura_tentativa #(
        .W               (W),
        .DEBOUNCE_CYCLES (DBC),
        .MAX_TENTATIVAS  (MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_enter_n     (key_enter_n),
        .sw_tentativa    (sw_tentativa),
        .novo_jogo       (novo_jogo),
        .tentativa       (tentativa),
        .tentativa_valid (tentativa_valid),
        .tentativa_ready (tentativa_ready),
        .num_tentativas  (num_tentativas),
        .esgotou         (esgotou)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          key_n;
        logic          ready;
        logic [W-1:0]  sw;
        logic          exp_valid;
        logic [W-1:0]  exp_tent;
        logic [CW-1:0] exp_num;
        logic          exp_esg;
    } vec_t;

    vec_t tab[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Waits up to 'bound' cycles for valid; an expired bound is a failed check.
    task automatic wait_valid(input string name, input int bound);
        int k;
        k = 0;
        while (tentativa_valid !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        chk(name, int'(tentativa_valid), 1);
    endtask

    // Holds the key for 'hold' cycles then releases for 10, with ready=1; returns valid cycles seen.
    task automatic press_and_count(input int hold, output int nvalid);
        nvalid = 0;
        tentativa_ready = 1'b1;
        key_enter_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (tentativa_valid === 1'b1) nvalid++;
        end
        key_enter_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tentativa_valid === 1'b1) nvalid++;
        end
    endtask

    initial begin
        int nv;
        int saw_valid;

        rst_n = 1'b0;
        key_enter_n = 1'b1;
        sw_tentativa = 6'h2D;
        novo_jogo = 1'b0;
        tentativa_ready = 1'b1;

        // Clean press trace: valid appears after the 7th edge, transfer on the 8th.
        for (int i = 0; i < 16; i++) begin
            tab[i].key_n     = (i < 8) ? 1'b0 : 1'b1;
            tab[i].ready     = 1'b1;
            tab[i].sw        = 6'h2D;
            tab[i].exp_valid = (i == 6) ? 1'b1 : 1'b0;
            tab[i].exp_tent  = (i >= 6) ? 6'h2D : 6'h00;
            tab[i].exp_num   = (i >= 7) ? 2'd1 : 2'd0;
            tab[i].exp_esg   = 1'b0;
        end

        step();
        step();
        chk("reset_tentativa", int'(tentativa), 0);
        chk("reset_valid", int'(tentativa_valid), 0);
        chk("reset_num", int'(num_tentativas), 0);
        chk("reset_esgotou", int'(esgotou), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            key_enter_n     = tab[i].key_n;
            tentativa_ready = tab[i].ready;
            sw_tentativa    = tab[i].sw;
            step();
            chk($sformatf("clean_press_cycle%0d", i + 1),
                int'({tentativa_valid, tentativa, num_tentativas, esgotou}),
                int'({tab[i].exp_valid, tab[i].exp_tent, tab[i].exp_num, tab[i].exp_esg}));
        end

        // Bounce: toggling every 2 cycles never yields 4 stable samples.
        saw_valid = 0;
        for (int i = 0; i < 20; i++) begin
            key_enter_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            if (tentativa_valid === 1'b1) saw_valid++;
        end
        key_enter_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tentativa_valid === 1'b1) saw_valid++;
        end
        chk("bounce_no_valid", saw_valid, 0);
        chk("bounce_num", int'(num_tentativas), 1);

        // Backpressure: guess held against switch changes and a second press.
        tentativa_ready = 1'b0;
        sw_tentativa = 6'h2D;
        key_enter_n = 1'b0;
        wait_valid("bp_valid", 20);
        chk("bp_tent", int'(tentativa), 6'h2D);
        sw_tentativa = 6'h07;
        key_enter_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        key_enter_n = 1'b0;
        for (int i = 0; i < 8; i++) step();
        key_enter_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("bp_hold_valid", int'(tentativa_valid), 1);
        chk("bp_hold_tent", int'(tentativa), 6'h2D);
        chk("bp_hold_num", int'(num_tentativas), 1);
        tentativa_ready = 1'b1;
        step();
        tentativa_ready = 1'b0;
        chk("bp_xfer_valid", int'(tentativa_valid), 0);
        chk("bp_xfer_num", int'(num_tentativas), 2);
        saw_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tentativa_valid === 1'b1) saw_valid++;
        end
        chk("bp_no_second_offer", saw_valid, 0);
        chk("bp_num_after", int'(num_tentativas), 2);

        // New game, then hold/release sequence up to lockout.
        novo_jogo = 1'b1;
        step();
        novo_jogo = 1'b0;
        chk("ng_num", int'(num_tentativas), 0);
        sw_tentativa = 6'h11;
        press_and_count(50, nv);
        chk("hold50_one_guess", nv, 1);
        chk("hold50_num", int'(num_tentativas), 1);
        chk("hold50_tent", int'(tentativa), 6'h11);
        press_and_count(15, nv);
        chk("second_guess", nv, 1);
        chk("second_num", int'(num_tentativas), 2);
        press_and_count(15, nv);
        chk("third_guess", nv, 1);
        chk("third_num", int'(num_tentativas), 3);
        chk("third_esgotou", int'(esgotou), 1);
        press_and_count(15, nv);
        chk("locked_no_guess", nv, 0);
        chk("locked_num", int'(num_tentativas), 3);
        chk("locked_esgotou", int'(esgotou), 1);

        // novo_jogo wins over a simultaneous transfer.
        novo_jogo = 1'b1;
        step();
        novo_jogo = 1'b0;
        chk("unlock_esgotou", int'(esgotou), 0);
        tentativa_ready = 1'b0;
        key_enter_n = 1'b0;
        wait_valid("coll_valid", 20);
        key_enter_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        tentativa_ready = 1'b1;
        novo_jogo = 1'b1;
        step();
        novo_jogo = 1'b0;
        tentativa_ready = 1'b0;
        chk("coll_valid_dropped", int'(tentativa_valid), 0);
        chk("coll_num", int'(num_tentativas), 0);
        chk("coll_esgotou", int'(esgotou), 0);
        press_and_count(15, nv);
        chk("after_coll_guess", nv, 1);
        chk("after_coll_num", int'(num_tentativas), 1);

        // Asynchronous reset while offering.
        tentativa_ready = 1'b0;
        key_enter_n = 1'b0;
        wait_valid("rst_offer_valid", 20);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(tentativa_valid), 0);
        chk("async_rst_num", int'(num_tentativas), 0);
        key_enter_n = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        press_and_count(15, nv);
        chk("post_rst_guess", nv, 1);
        chk("post_rst_num", int'(num_tentativas), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
